// File: rtl/majority_voter.sv
// -----------------------------------------------------------------------------
// majority_voter
//
// Bitwise majority voter over N_CH redundant channels with per-channel fault
// tracking. Each valid sample is voted bit by bit (a bit is 1 when at least
// (N_CH+1)/2 channels carry a 1). The voted word and the per-channel mismatch
// vector are registered, giving one cycle of latency.
//
// Every channel keeps a 4-bit saturating consecutive-mismatch counter and a
// small OK / SUSPECT / FAULT state machine. A channel that mismatches
// FAULT_TH valid samples in a row is latched in FAULT until fault_clr or rst.
// Faulted channels still take part in the vote.
//
// Optional feature: define MAJORITY_VOTER_ERRCNT_EN to add err_cnt, a set of
// per-channel 16-bit saturating totals of mismatching valid samples. These
// totals are cleared only by rst.
//
// Parameters
//   N_CH     : number of voted channels (odd: 3, 5, 7)
//   W        : width of each channel word
//   FAULT_TH : consecutive mismatches before a channel is faulted (1..15)
//
// Ports
//   clk       in   1        clock, rising edge
//   rst       in   1        synchronous active-high reset
//   in_valid  in   1        in_data holds a sample to vote
//   in_data   in   N_CH*W   channel i at [i*W +: W]
//   fault_clr in   1        pulse: clear all fault tracking (not the totals)
//   out_valid out  1        out_data holds a new voted word this cycle
//   out_data  out  W        registered majority word
//   mismatch  out  N_CH     channel i differed from the vote in last valid sample
//   fault     out  N_CH     channel i is in FAULT
//   err_cnt   out  N_CH*16  per-channel mismatch totals (ERRCNT_EN builds only)
// -----------------------------------------------------------------------------
module majority_voter #(
   parameter int N_CH     = 3,
   parameter int W        = 8,
   parameter int FAULT_TH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [N_CH*W-1:0]   in_data,
   input  logic                fault_clr,
   output logic                out_valid,
   output logic [W-1:0]        out_data,
   output logic [N_CH-1:0]     mismatch,
   output logic [N_CH-1:0]     fault
`ifdef MAJORITY_VOTER_ERRCNT_EN
   ,
   output logic [N_CH*16-1:0]  err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } ch_state_e;

   localparam int         MAJ    = (N_CH + 1) / 2;
   localparam logic [3:0] TH     = 4'(FAULT_TH);
   localparam logic [3:0] CNT_MAX = 4'hF;

   // Bitwise majority: count the ones in each bit column.
   function automatic logic [W-1:0] vote(input logic [N_CH*W-1:0] d);
      logic [W-1:0] r;
      int           ones;
      r = '0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         for (int c = 0; c < N_CH; c++) begin
            ones += int'(d[c*W + b]);
         end
         r[b] = (ones >= MAJ);
      end
      return r;
   endfunction

   // Saturating increment of a consecutive-mismatch counter.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + 4'd1;
   endfunction

   logic [W-1:0]    voted;
   logic [N_CH-1:0] mm;

   logic            out_valid_q;
   logic [W-1:0]    out_data_q;
   logic [N_CH-1:0] mismatch_q;

   ch_state_e       state_q [N_CH];
   ch_state_e       state_d [N_CH];
   logic [3:0]      cnt_q   [N_CH];
   logic [3:0]      cnt_d   [N_CH];

   // ---------------------------------------------------------------------------
   // Vote and per-channel comparison of the incoming sample
   // ---------------------------------------------------------------------------
   always_comb begin
      voted = vote(in_data);
      mm    = '0;
      for (int i = 0; i < N_CH; i++) begin
         mm[i] = (in_data[i*W +: W] != voted);
      end
   end

   // ---------------------------------------------------------------------------
   // Per-channel fault FSM, next state
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [3:0] inc;
      inc = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         inc        = sat_inc4(cnt_q[i]);
         if (fault_clr) begin
            // Clear wins over a simultaneous sample; that sample is not counted.
            state_d[i] = ST_OK;
            cnt_d[i]   = 4'd0;
         end else if (in_valid) begin
            unique case (state_q[i])
               ST_OK, ST_SUSPECT: begin
                  if (mm[i]) begin
                     // From OK the counter restarts at 1 (inc of 0); with
                     // FAULT_TH=1 that already reaches the threshold.
                     cnt_d[i]   = inc;
                     state_d[i] = (inc >= TH) ? ST_FAULT : ST_SUSPECT;
                  end else begin
                     cnt_d[i]   = 4'd0;
                     state_d[i] = ST_OK;
                  end
               end
               ST_FAULT: begin
                  // Counter frozen, state sticky until fault_clr or rst.
                  state_d[i] = ST_FAULT;
               end
               default: begin
                  state_d[i] = ST_OK;
                  cnt_d[i]   = 4'd0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output and FSM registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         mismatch_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= ST_OK;
            cnt_q[i]   <= 4'd0;
         end
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            out_data_q <= voted;
            mismatch_q <= mm;
         end
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      fault = '0;
      for (int i = 0; i < N_CH; i++) begin
         fault[i] = (state_q[i] == ST_FAULT);
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign mismatch  = mismatch_q;

`ifdef MAJORITY_VOTER_ERRCNT_EN
   // ---------------------------------------------------------------------------
   // Lifetime mismatch totals: every mismatching valid sample counts, including
   // one that arrives with fault_clr and one from an already faulted channel.
   // ---------------------------------------------------------------------------
   logic [15:0] err_q [N_CH];
   logic [15:0] err_d [N_CH];

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         err_d[i] = err_q[i];
         if (in_valid && mm[i] && (err_q[i] != 16'hFFFF)) begin
            err_d[i] = err_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            err_q[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            err_q[i] <= err_d[i];
         end
      end
   end

   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         err_cnt[i*16 +: 16] = err_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_majority_voter.sv
module tb_majority_voter;
   localparam int N_CH     = 3;
   localparam int W        = 8;
   localparam int FAULT_TH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                in_valid;
   logic                fault_clr;
   logic [N_CH*W-1:0]   in_data;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [N_CH-1:0]     mismatch;
   logic [N_CH-1:0]     fault;
`ifdef MAJORITY_VOTER_ERRCNT_EN
   logic [N_CH*16-1:0]  err_cnt;
`endif

   majority_voter #(.N_CH(N_CH), .W(W), .FAULT_TH(FAULT_TH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .fault_clr (fault_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .mismatch  (mismatch),
      .fault     (fault)
`ifdef MAJORITY_VOTER_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic       m_valid;
   logic [7:0] m_data;
   logic [2:0] m_mm;
   int         streak  [3];
   bit         faulted [3];
   int         total   [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pack(input logic [7:0] c2, input logic [7:0] c1, input logic [7:0] c0);
      return {c2, c1, c0};
   endfunction

   task automatic model_update(input logic r, input logic v, input logic c, input logic [23:0] d);
      logic [7:0] a, b, e, vt;
      logic [2:0] smm;
      if (r) begin
         m_valid = 1'b0; m_data = 8'h00; m_mm = 3'b000;
         for (int i = 0; i < 3; i++) begin
            streak[i] = 0; faulted[i] = 1'b0; total[i] = 0;
         end
      end else begin
         a = d[7:0]; b = d[15:8]; e = d[23:16];
         vt  = (a & b) | (a & e) | (b & e);
         smm = {e != vt, b != vt, a != vt};
         m_valid = v;
         if (v) begin
            m_data = vt;
            m_mm   = smm;
         end
         for (int i = 0; i < 3; i++) begin
            if (v && smm[i] && total[i] < 65535) total[i]++;
            if (c) begin
               streak[i] = 0; faulted[i] = 1'b0;
            end else if (v && !faulted[i]) begin
               streak[i] = smm[i] ? ((streak[i] < 15) ? streak[i] + 1 : 15) : 0;
               if (streak[i] >= FAULT_TH) faulted[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic v, input logic c, input logic [23:0] d);
      rst = r; in_valid = v; fault_clr = c; in_data = d;
      @(posedge clk);
      model_update(r, v, c, d);
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data",  32'(out_data),  32'(m_data));
      check("mismatch",  32'(mismatch),  32'(m_mm));
      check("fault",     32'(fault),     32'({faulted[2], faulted[1], faulted[0]}));
`ifdef MAJORITY_VOTER_ERRCNT_EN
      for (int i = 0; i < 3; i++)
         check($sformatf("err_cnt%0d", i), 32'(err_cnt[i*16 +: 16]), 32'(total[i]));
`endif
   endtask

   localparam logic [23:0] GOOD  = 24'h333333;
   localparam logic [23:0] BAD2  = 24'hCC3333;
   localparam logic [23:0] BAD1  = 24'h33CC33;
   localparam logic [23:0] BAD0  = 24'h3333CC;

   initial begin
      logic [7:0]  base;
      logic [7:0]  ch [3];
      int          k;
      logic        rr, vv, cc;

      // Reset state
      step(1, 0, 0, 24'h0);
      step(1, 1, 1, BAD2);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_fault",     32'(fault),     32'h0);

      // All channels equal
      step(0, 1, 0, pack(8'h5A, 8'h5A, 8'h5A));
      check("eq_data", 32'(out_data), 32'h5A);
      check("eq_mm",   32'(mismatch), 32'h0);

      // Bitwise vote
      step(0, 1, 0, pack(8'hF0, 8'h0F, 8'hFF));
      check("bw_data", 32'(out_data), 32'hFF);
      check("bw_mm",   32'(mismatch), 32'b110);
      step(0, 1, 0, GOOD);

      // Fault entry interrupted by a match, then four in a row
      step(0, 1, 0, BAD2); step(0, 1, 0, BAD2); step(0, 1, 0, BAD2);
      step(0, 1, 0, GOOD);
      step(0, 1, 0, BAD2);
      check("interrupted_fault", 32'(fault), 32'b000);
      step(0, 1, 0, BAD2); step(0, 1, 0, BAD2);
      check("pre_fault", 32'(fault), 32'b000);
      step(0, 1, 0, BAD2);
      check("fault_entry", 32'(fault), 32'b100);
      step(0, 1, 0, GOOD);
      check("fault_sticky", 32'(fault), 32'b100);

      // Clear priority over a mismatching sample
      step(0, 1, 1, BAD2);
      check("clr_fault", 32'(fault),    32'b000);
      check("clr_mm",    32'(mismatch), 32'b100);
      step(0, 1, 0, BAD2); step(0, 1, 0, BAD2); step(0, 1, 0, BAD2);
      check("clr_refault_pre", 32'(fault), 32'b000);
      step(0, 1, 0, BAD2);
      check("clr_refault", 32'(fault), 32'b100);

      // Idle gaps between ch1 mismatches
      step(0, 0, 1, 24'h0);
      step(0, 1, 0, BAD1); step(0, 0, 0, BAD2);
      check("gap_valid", 32'(out_valid), 32'h0);
      check("gap_hold",  32'(mismatch),  32'b010);
      step(0, 1, 0, BAD1); step(0, 0, 0, 24'h0); step(0, 0, 0, 24'h0);
      step(0, 1, 0, BAD1); step(0, 0, 0, 24'h0);
      step(0, 1, 0, BAD1);
      check("gap_fault", 32'(fault), 32'b010);
      step(0, 0, 0, 24'h0);
      check("gap_fault_hold", 32'(fault), 32'b010);
      step(1, 1, 0, BAD0);
      check("rst2_valid", 32'(out_valid), 32'h0);
      check("rst2_data",  32'(out_data),  32'h0);
      check("rst2_fault", 32'(fault),     32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         base = 8'($urandom);
         for (int i = 0; i < 3; i++) ch[i] = base;
         k = $urandom_range(0, 4);
         if (k < 3) ch[k] = 8'($urandom);
         if ($urandom_range(0, 9) == 0) ch[$urandom_range(0, 2)] = 8'($urandom);
         rr = ($urandom_range(0, 99) == 0);
         vv = ($urandom_range(0, 3) != 0);
         cc = ($urandom_range(0, 19) == 0);
         step(rr, vv, cc, pack(ch[2], ch[1], ch[0]));
      end

`ifdef MAJORITY_VOTER_ERRCNT_EN
      // Total counter saturation, survives fault_clr, cleared by rst
      step(1, 0, 0, 24'h0);
      for (int n = 0; n < 70000; n++) step(0, 1, 0, BAD0);
      check("errcnt_sat", 32'(err_cnt[15:0]), 32'hFFFF);
      step(0, 0, 1, 24'h0);
      check("errcnt_clr", 32'(err_cnt[15:0]), 32'hFFFF);
      step(1, 0, 0, 24'h0);
      check("errcnt_rst", 32'(err_cnt[15:0]), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/majority_voter.md
MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 SHALL have parameter N_CH, default 3, meaning the odd number of voted channels (legal 3, 5, 7).
REQ-002 SHALL have parameter W, default 8, meaning the width of each channel word in bits.
REQ-003 SHALL have parameter FAULT_TH, default 4, meaning consecutive mismatching samples before a channel is faulted (legal 1..15).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  meaning the current in_data is a sample to vote.
REQ-007 SHALL have port in_data  input  N_CH*W  meaning the channel words, with channel i at bits [i*W+W-1 : i*W].
REQ-008 SHALL have port fault_clr  input  1  meaning a one-cycle pulse that clears all channel fault tracking.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a new voted word this cycle.
REQ-010 SHALL have port out_data  output  W  meaning the registered bitwise majority word.
REQ-011 SHALL have port mismatch  output  N_CH  meaning bit i is high when channel i differed from the voted word in the last valid sample.
REQ-012 SHALL have port fault  output  N_CH  meaning bit i is a sticky flag showing channel i is faulted.

Function
REQ-013 SHALL set voted bit b to 1 iff at least (N_CH+1)/2 channels have bit b = 1; every channel, including faulted ones, always takes part in the vote.
REQ-014 SHALL apply one-cycle latency: in_valid high at edge k gives out_valid=1 and the voted out_data after edge k, with mismatch updated in the same cycle.
REQ-015 SHALL drive out_valid low in any cycle following a cycle with in_valid low, and SHALL hold out_data and mismatch unchanged in that case.
REQ-016 SHALL keep, per channel, a saturating 4-bit consecutive-mismatch counter and an FSM with states OK, SUSPECT and FAULT, updated only on valid samples or fault_clr.
REQ-017 SHALL make these FSM transitions:
- OK to SUSPECT on a mismatch, with counter set to 1.
- SUSPECT to OK on a match, with counter set to 0.
- SUSPECT stays in SUSPECT on a mismatch, with counter incremented.
- SUSPECT or OK to FAULT when the counter reaches FAULT_TH.
- FAULT to OK only through fault_clr or rst.
REQ-018 SHALL, when FAULT_TH=1, move a channel from OK straight to FAULT on its first mismatch.
REQ-019 SHALL hold the counter at its value once a channel is in FAULT, and SHALL drive fault[i] high exactly while channel i is in FAULT.
REQ-020 SHALL give fault_clr priority over a simultaneous valid sample:
- all channels go to OK and all counters go to 0.
- the sample is still voted and mismatch is still reported, but the sample is not counted.
REQ-021 SHALL, when in_valid is low, hold all counters and states, except for the effect of fault_clr.

Reset
REQ-022 SHALL, on rst high at a clock edge, set out_valid=0, out_data=0, mismatch=0, fault=0, all counters to 0 and all FSMs to OK.
REQ-023 SHALL let rst override in_valid and fault_clr in the same cycle, and SHALL discard any vote in flight, so out_valid is 0 in the cycle after reset.

Configuration
REQ-024 SHALL, when MAJORITY_VOTER_ERRCNT_EN is defined, add output port err_cnt (N_CH*16) holding per-channel 16-bit saturating totals of all mismatching valid samples:
- a total saturates at 16'hFFFF.
- totals are cleared only by rst; fault_clr does not clear them.
REQ-025 SHALL, when MAJORITY_VOTER_ERRCNT_EN is undefined, have no err_cnt port and no total counters, with all other behaviour identical.

Verification (N_CH=3, W=8, FAULT_TH=4)
REQ-026 SHALL cover all channels equal: in_data={8'h5A,8'h5A,8'h5A} with in_valid=1 -> next cycle out_valid=1, out_data=8'h5A, mismatch=3'b000.
REQ-027 SHALL cover bitwise vote: ch0=8'hFF, ch1=8'h0F, ch2=8'hF0 -> out_data=8'hFF, mismatch=3'b110.
REQ-028 SHALL cover fault entry: ch2 mismatches on 4 consecutive valid samples -> fault=3'b100 after the 4th; with a match between mismatches 3 and 4, fault stays 3'b000.
REQ-029 SHALL cover clear priority: fault_clr=1 together with a ch2-mismatching sample -> fault=0, ch2 counter=0, mismatch[2]=1; 4 further mismatches are needed to fault again.
REQ-030 SHALL cover idle cycles and reset: in_valid gaps between 4 ch1 mismatches -> fault[1] still set and out_valid low in the gap cycles; then rst -> all outputs 0.
REQ-031 SHALL cover ERRCNT_EN: 70000 ch0 mismatches -> err_cnt[15:0]=16'hFFFF; fault_clr leaves it unchanged; rst sets it to 0.
